// File: rtl/hp_au_pkg.sv
// Shared definitions for the hp_au_seq digit-serial adder/subtractor.
// Holds the operation encodings and the controller state type.
package hp_au_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_BCD  = 2'b10;
    localparam logic [1:0] OP_ADD2 = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/hp_au_digit_slice.sv
// One 4-bit digit of add / subtract / BCD add, purely combinational.
// Ports: i_a, i_b digits, i_cin carry-in, i_sel op code;
//        o_sum digit result, o_cout digit carry-out.
// Macro HP_AU_SEQ_BCD_EN enables the decimal correction for OP_BCD.
module hp_au_digit_slice
    import hp_au_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    input  logic [1:0] i_sel,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_b;
    logic [4:0] w_raw;

    // Subtraction is A + ~B with the carry preloaded to 1 by the caller.
    assign w_b   = (i_sel == OP_SUB) ? ~i_b : i_b;
    assign w_raw = {1'b0, i_a} + {1'b0, w_b} + {4'b0000, i_cin};

`ifdef HP_AU_SEQ_BCD_EN
    always_comb begin
        o_sum  = w_raw[3:0];
        o_cout = w_raw[4];
        // Decimal adjust: any raw sum above 9 wraps by +6 and carries.
        if (i_sel == OP_BCD && w_raw > 5'd9) begin
            o_sum  = w_raw[3:0] + 4'd6;
            o_cout = 1'b1;
        end
    end
`else
    assign o_sum  = w_raw[3:0];
    assign o_cout = w_raw[4];
`endif

endmodule

// File: rtl/hp_au_seq.sv
// Digit-serial add/sub/BCD unit: one 4-bit digit per clock, LSD first.
// Ports: clk, rst (async high); in_valid/in_ready with a, b, sel;
//        out_valid/out_ready with result, cout (cout=1: no borrow on sub).
// Macro HP_AU_SEQ_BCD_EN enables BCD add for sel=10 (else binary add).
module hp_au_seq
    import hp_au_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic [1:0]            sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_acc;
    logic [1:0]    r_sel;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_result;
    logic          r_cout;
    logic          r_valid;

    logic [CW+1:0] w_idx;
    logic [3:0]    w_a_dig;
    logic [3:0]    w_b_dig;
    logic [3:0]    w_sum;
    logic          w_dcout;
    logic          w_last;
    logic [W-1:0]  w_acc_next;

    // Bit offset of the current digit.
    assign w_idx   = {r_cnt, 2'b00};
    assign w_a_dig = r_a[w_idx +: 4];
    assign w_b_dig = r_b[w_idx +: 4];
    assign w_last  = (r_cnt == CW'(DIGITS - 1));

    hp_au_digit_slice u_slice (
        .i_a    (w_a_dig),
        .i_b    (w_b_dig),
        .i_cin  (r_carry),
        .i_sel  (r_sel),
        .o_sum  (w_sum),
        .o_cout (w_dcout)
    );

    // Working accumulator with the current digit merged in, so the
    // final digit can be published in the same edge it is computed.
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[w_idx +: 4] = w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_sel    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sel   <= sel;
                        r_cnt   <= '0;
                        r_carry <= (sel == OP_SUB);
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_dcout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_acc_next;
                        r_cout   <= w_dcout;
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_valid;
    assign result    = r_result;
    assign cout      = r_cout;

endmodule

// File: tb/tb_hp_au_seq.sv
// Self-checking bench for hp_au_seq (DIGITS=4): directed table,
// random ops against an arithmetic model, back-pressure and reset cases.
module tb_hp_au_seq;

    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;

    int n_checks;
    int n_errors;

    hp_au_seq #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  sel;
        logic [15:0] res;
        logic        c;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic for add/sub, decimal digit rule
    // for BCD when enabled.
    function automatic void model(input logic [15:0] ma,
                                  input logic [15:0] mb,
                                  input logic [1:0] ms,
                                  output logic [15:0] mr,
                                  output logic mc);
        int sum;
        int c;
        int d;
        mr = 16'h0;
        mc = 1'b0;
        if (ms == 2'b01) begin
            mr = 16'(int'(ma) - int'(mb));
            mc = (ma >= mb);
        end else begin
`ifdef HP_AU_SEQ_BCD_EN
            if (ms == 2'b10) begin
                c = 0;
                for (int i = 0; i < 4; i++) begin
                    d = ((int'(ma) >> (4 * i)) & 15) +
                        ((int'(mb) >> (4 * i)) & 15) + c;
                    if (d > 9) begin
                        d = (d + 6) & 15;
                        c = 1;
                    end else begin
                        c = 0;
                    end
                    mr = mr | 16'(d << (4 * i));
                end
                mc = c[0];
                return;
            end
`endif
            sum = int'(ma) + int'(mb);
            mr = sum[15:0];
            mc = sum[16];
        end
    endfunction

    task automatic scramble();
        a   = 16'($urandom);
        b   = 16'($urandom);
        sel = 2'($urandom);
    endtask

    // Issue one op, check latency, hold out_ready low for 'hold'
    // cycles checking stability, then consume the result.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic [1:0] ts, input int hold,
                          output logic [15:0] r, output logic c);
        int k;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        sel = ts;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin
            scramble();
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(DIGITS));
        r = result;
        c = cout;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            scramble();
            @(negedge clk);
            chk("hold_result", 32'(result), 32'(r));
            chk("hold_cout", 32'(cout), 32'(c));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consumed_valid", 32'(out_valid), 32'd0);
        chk("back_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] r;
        logic        c;
        logic [15:0] er;
        logic        ec;
        int          seen;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        sel = '0;

        vecs[0] = '{16'h1234, 16'h0FFF, 2'b00, 16'h2233, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 2'b01, 16'hFFFE, 1'b0};
        vecs[2] = '{16'h0007, 16'h0005, 2'b01, 16'h0002, 1'b1};
`ifdef HP_AU_SEQ_BCD_EN
        vecs[3] = '{16'h9999, 16'h0001, 2'b10, 16'h0000, 1'b1};
`else
        vecs[3] = '{16'h0009, 16'h0001, 2'b10, 16'h000A, 1'b0};
`endif
        vecs[4] = '{16'hFFFF, 16'h0001, 2'b11, 16'h0000, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 2'b01, 16'h0000, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sel, (i == 0) ? 5 : 0,
                   r, c);
            chk("vec_result", 32'(r), 32'(vecs[i].res));
            chk("vec_cout", 32'(c), 32'(vecs[i].c));
        end

        for (int n = 0; n < 40; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic [1:0]  rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 2'($urandom);
            model(ra, rb, rs, er, ec);
            run_op(ra, rb, rs, int'($urandom_range(0, 3)), r, c);
            chk("rand_result", 32'(r), 32'(er));
            chk("rand_cout", 32'(c), 32'(ec));
        end

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        sel = 2'b00;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_valid_after_rst", 32'(seen), 32'd0);
        run_op(16'h0001, 16'h0001, 2'b00, 0, r, c);
        chk("post_rst_result", 32'(r), 32'h0002);
        chk("post_rst_cout", 32'(c), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
